// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the mem_access stage (master)
// and the data memory (slave).
interface mem_access_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: performs loads/stores over a req/ack bus,
// stalls upstream while a request is outstanding, and registers writeback controls.
module mem_access #(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [3:0]        ex_rd_num,
    input  logic [DATA_W-1:0] ex_rd_val,
    input  logic [DATA_W-1:0] ex_md,
    input  logic [DATA_W-1:0] ex_cpsr,
    input  logic              ex_taken,
    input  logic              ex_is_alu,
    input  logic              ex_is_cmp,
    input  logic              ex_is_jmp,
    input  logic              ex_is_ld,
    input  logic              ex_is_str,

    mem_access_if.master      mem,

    output logic              wb_valid,
    output logic              wb_rd_we,
    output logic [3:0]        wb_rd_num,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_cpsr_we,
    output logic [DATA_W-1:0] wb_cpsr,
    output logic              wb_pc_we,
    output logic [DATA_W-1:0] wb_pc,

    output logic              bus_err,
    input  logic              err_clr
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Last WAIT cycle index before the access is abandoned.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [0:0]        state_q,      state_d;
    logic [15:0]       cnt_q,        cnt_d;
    logic [3:0]        rd_q,         rd_d;

    logic              req_q,        req_d;
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;

    logic              wb_valid_q,   wb_valid_d;
    logic              wb_rd_we_q,   wb_rd_we_d;
    logic [3:0]        wb_rd_num_q,  wb_rd_num_d;
    logic [DATA_W-1:0] wb_data_q,    wb_data_d;
    logic              wb_cpsr_we_q, wb_cpsr_we_d;
    logic [DATA_W-1:0] wb_cpsr_q,    wb_cpsr_d;
    logic              wb_pc_we_q,   wb_pc_we_d;
    logic [DATA_W-1:0] wb_pc_q,      wb_pc_d;
    logic              err_q,        err_d;

    logic              is_mem_op;

    assign is_mem_op = ex_is_ld | ex_is_str;
    assign in_ready  = (state_q == S_IDLE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wb_valid_d   = 1'b0;
        wb_rd_we_d   = 1'b0;
        wb_cpsr_we_d = 1'b0;
        wb_pc_we_d   = 1'b0;
        wb_rd_num_d  = wb_rd_num_q;
        wb_data_d    = wb_data_q;
        wb_cpsr_d    = wb_cpsr_q;
        wb_pc_d      = wb_pc_q;
        err_d        = err_q & ~err_clr;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_mem_op) begin
                        // Load outranks store when both flags are raised.
                        req_d   = 1'b1;
                        we_d    = ~ex_is_ld;
                        addr_d  = ex_md[ADDR_W-1:0];
                        wdata_d = ex_rd_val;
                        rd_d    = ex_rd_num;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        wb_valid_d = 1'b1;
                        if (ex_is_alu) begin
                            wb_rd_we_d  = 1'b1;
                            wb_rd_num_d = ex_rd_num;
                            wb_data_d   = ex_result;
                        end else if (ex_is_cmp) begin
                            wb_cpsr_we_d = 1'b1;
                            wb_cpsr_d    = ex_cpsr;
                        end else if (ex_is_jmp) begin
                            wb_pc_we_d = ex_taken;
                            wb_pc_d    = ex_md;
                        end
                    end
                end
            end

            S_WAIT: begin
                if (mem.ack) begin
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    state_d    = S_IDLE;
                    if (!we_q) begin
                        wb_rd_we_d  = 1'b1;
                        wb_rd_num_d = rd_q;
                        wb_data_d   = mem.rdata;
                    end
                end else if (cnt_q == TO_LAST) begin
                    // Abandon the access; the writeback pulse carries no enables.
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    err_d      = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rd_q         <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_we_q   <= 1'b0;
            wb_rd_num_q  <= '0;
            wb_data_q    <= '0;
            wb_cpsr_we_q <= 1'b0;
            wb_cpsr_q    <= '0;
            wb_pc_we_q   <= 1'b0;
            wb_pc_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_we_q   <= wb_rd_we_d;
            wb_rd_num_q  <= wb_rd_num_d;
            wb_data_q    <= wb_data_d;
            wb_cpsr_we_q <= wb_cpsr_we_d;
            wb_cpsr_q    <= wb_cpsr_d;
            wb_pc_we_q   <= wb_pc_we_d;
            wb_pc_q      <= wb_pc_d;
            err_q        <= err_d;
        end
    end

    assign mem.req    = req_q;
    assign mem.we     = we_q;
    assign mem.addr   = addr_q;
    assign mem.wdata  = wdata_q;

    assign wb_valid   = wb_valid_q;
    assign wb_rd_we   = wb_rd_we_q;
    assign wb_rd_num  = wb_rd_num_q;
    assign wb_data    = wb_data_q;
    assign wb_cpsr_we = wb_cpsr_we_q;
    assign wb_cpsr    = wb_cpsr_q;
    assign wb_pc_we   = wb_pc_we_q;
    assign wb_pc      = wb_pc_q;
    assign bus_err    = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: vector table for single-cycle ops, hand sequences
// for memory corner cases, then randomized ops against a transaction-level model.
module tb_mem_access;
    localparam int TO = 4;

    localparam logic [4:0] F_LD  = 5'b10000;
    localparam logic [4:0] F_STR = 5'b01000;
    localparam logic [4:0] F_ALU = 5'b00100;
    localparam logic [4:0] F_CMP = 5'b00010;
    localparam logic [4:0] F_JMP = 5'b00001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ex_result = '0, ex_rd_val = '0, ex_md = '0, ex_cpsr = '0;
    logic [3:0]  ex_rd_num = '0;
    logic        ex_taken = 1'b0;
    logic [4:0]  flags = '0;
    logic        wb_valid, wb_rd_we, wb_cpsr_we, wb_pc_we, bus_err;
    logic [3:0]  wb_rd_num;
    logic [31:0] wb_data, wb_cpsr, wb_pc;
    logic        err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_access_if #(.ADDR_W(22), .DATA_W(32)) bus ();

    mem_access #(.ADDR_W(22), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ex_result(ex_result), .ex_rd_num(ex_rd_num), .ex_rd_val(ex_rd_val),
        .ex_md(ex_md), .ex_cpsr(ex_cpsr), .ex_taken(ex_taken),
        .ex_is_alu(flags[2]), .ex_is_cmp(flags[1]), .ex_is_jmp(flags[0]),
        .ex_is_ld(flags[4]), .ex_is_str(flags[3]),
        .mem(bus),
        .wb_valid(wb_valid), .wb_rd_we(wb_rd_we), .wb_rd_num(wb_rd_num),
        .wb_data(wb_data), .wb_cpsr_we(wb_cpsr_we), .wb_cpsr(wb_cpsr),
        .wb_pc_we(wb_pc_we), .wb_pc(wb_pc),
        .bus_err(bus_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  fl;
        logic [3:0]  rd;
        logic [31:0] res, md, cpsr;
        logic        tk;
        logic        e_v, e_rw, e_cw, e_pw;
        logic [3:0]  e_rd;
        logic [31:0] e_data, e_cpsr, e_pc;
    } vec_t;

    vec_t vt[9];

    // Reference-model writeback state
    logic        m_v, m_rw, m_cw, m_pw, m_err;
    logic [3:0]  m_rd;
    logic [31:0] m_data, m_cpsr, m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] fl, input logic [3:0] rd,
                         input logic [31:0] res, input logic [31:0] rdval,
                         input logic [31:0] md, input logic [31:0] cpsr, input logic tk);
        in_valid  = v;
        flags     = fl;
        ex_rd_num = rd;
        ex_result = res;
        ex_rd_val = rdval;
        ex_md     = md;
        ex_cpsr   = cpsr;
        ex_taken  = tk;
    endtask

    function automatic vec_t mk(input logic v, input logic [4:0] fl, input logic [3:0] rd,
                                input logic [31:0] res, input logic [31:0] md,
                                input logic [31:0] cpsr, input logic tk,
                                input logic ev, input logic erw, input logic ecw, input logic epw,
                                input logic [3:0] erd, input logic [31:0] edata,
                                input logic [31:0] ecpsr, input logic [31:0] epc);
        vec_t r;
        r.v = v; r.fl = fl; r.rd = rd; r.res = res; r.md = md; r.cpsr = cpsr; r.tk = tk;
        r.e_v = ev; r.e_rw = erw; r.e_cw = ecw; r.e_pw = epw;
        r.e_rd = erd; r.e_data = edata; r.e_cpsr = ecpsr; r.e_pc = epc;
        return r;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".wb_valid"},   32'(wb_valid),   32'(m_v));
        chk({tag, ".wb_rd_we"},   32'(wb_rd_we),   32'(m_rw));
        chk({tag, ".wb_cpsr_we"}, 32'(wb_cpsr_we), 32'(m_cw));
        chk({tag, ".wb_pc_we"},   32'(wb_pc_we),   32'(m_pw));
        chk({tag, ".wb_rd_num"},  32'(wb_rd_num),  32'(m_rd));
        chk({tag, ".wb_data"},    wb_data,         m_data);
        chk({tag, ".wb_cpsr"},    wb_cpsr,         m_cpsr);
        chk({tag, ".wb_pc"},      wb_pc,           m_pc);
        chk({tag, ".bus_err"},    32'(bus_err),    32'(m_err));
        chk({tag, ".mem_req"},    32'(bus.req),    32'd0);
        chk({tag, ".in_ready"},   32'(in_ready),   32'd1);
    endtask

    initial begin
        bus.ack   = 1'b0;
        bus.rdata = '0;

        vt[0] = mk(1, F_ALU, 3, 32'h1234, 0, 0, 0,     1, 1, 0, 0, 3, 32'h1234, 0, 0);
        vt[1] = mk(1, F_ALU, 7, 32'hCAFE0001, 0, 0, 0, 1, 1, 0, 0, 7, 32'hCAFE0001, 0, 0);
        vt[2] = mk(1, F_CMP, 0, 0, 0, 32'h8, 0,        1, 0, 1, 0, 7, 32'hCAFE0001, 32'h8, 0);
        vt[3] = mk(1, F_JMP, 0, 0, 32'h100, 0, 1,      1, 0, 0, 1, 7, 32'hCAFE0001, 32'h8, 32'h100);
        vt[4] = mk(1, F_JMP, 0, 0, 32'h200, 0, 0,      1, 0, 0, 0, 7, 32'hCAFE0001, 32'h8, 32'h200);
        vt[5] = mk(1, 5'b0, 0, 0, 0, 0, 0,             1, 0, 0, 0, 7, 32'hCAFE0001, 32'h8, 32'h200);
        vt[6] = mk(0, F_ALU, 1, 32'hFFFF, 0, 0, 0,     0, 0, 0, 0, 7, 32'hCAFE0001, 32'h8, 32'h200);
        vt[7] = mk(1, F_ALU | F_CMP | F_JMP, 9, 32'h55, 32'h300, 32'h4, 1,
                                                       1, 1, 0, 0, 9, 32'h55, 32'h8, 32'h200);
        vt[8] = mk(1, F_CMP | F_JMP, 0, 0, 32'h400, 32'h2, 1,
                                                       1, 0, 1, 0, 9, 32'h55, 32'h2, 32'h200);

        // Reset state
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("rst.wb_valid", 32'(wb_valid), 0);
        chk("rst.wb_data",  wb_data,       0);
        chk("rst.wb_pc",    wb_pc,         0);
        chk("rst.mem_req",  32'(bus.req),  0);
        chk("rst.mem_addr", 32'(bus.addr), 0);
        chk("rst.bus_err",  32'(bus_err),  0);
        chk("rst.in_ready", 32'(in_ready), 1);

        // Single-cycle ops from the vector table
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].v, vt[i].fl, vt[i].rd, vt[i].res, 0, vt[i].md, vt[i].cpsr, vt[i].tk);
            tick();
            m_v = vt[i].e_v; m_rw = vt[i].e_rw; m_cw = vt[i].e_cw; m_pw = vt[i].e_pw;
            m_rd = vt[i].e_rd; m_data = vt[i].e_data; m_cpsr = vt[i].e_cpsr; m_pc = vt[i].e_pc;
            m_err = 1'b0;
            check_model($sformatf("vec%0d", i));
        end

        // Load with ack on the third WAIT cycle
        drive(1, F_LD, 5, 0, 0, 32'h40, 0, 0);
        tick();
        chk("ld.req",      32'(bus.req),  1);
        chk("ld.we",       32'(bus.we),   0);
        chk("ld.addr",     32'(bus.addr), 32'h40);
        chk("ld.in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.ack   = (k == 2);
            bus.rdata = (k == 2) ? 32'hDEADBEEF : 32'h0;
            tick();
            if (k < 2) begin
                chk("ld.hold_req",   32'(bus.req),  1);
                chk("ld.hold_addr",  32'(bus.addr), 32'h40);
                chk("ld.hold_ready", 32'(in_ready), 0);
                chk("ld.hold_wbv",   32'(wb_valid), 0);
            end
        end
        bus.ack = 1'b0;
        chk("ld.wb_valid",  32'(wb_valid),  1);
        chk("ld.wb_rd_we",  32'(wb_rd_we),  1);
        chk("ld.wb_rd_num", 32'(wb_rd_num), 5);
        chk("ld.wb_data",   wb_data,        32'hDEADBEEF);
        chk("ld.req_drop",  32'(bus.req),   0);
        chk("ld.ready",     32'(in_ready),  1);
        tick();
        chk("ld.pulse_end", 32'(wb_valid),  0);
        chk("ld.we_end",    32'(wb_rd_we),  0);
        chk("ld.data_hold", wb_data,        32'hDEADBEEF);

        // Store at the top of the address space with immediate ack
        drive(1, F_STR, 2, 0, 32'hA5A5A5A5, 32'h003FFFFF, 0, 0);
        tick();
        chk("st.req",   32'(bus.req),   1);
        chk("st.we",    32'(bus.we),    1);
        chk("st.addr",  32'(bus.addr),  32'h3FFFFF);
        chk("st.wdata", bus.wdata,      32'hA5A5A5A5);
        in_valid = 1'b0;
        bus.ack  = 1'b1;
        tick();
        bus.ack  = 1'b0;
        chk("st.wb_valid", 32'(wb_valid),   1);
        chk("st.rd_we",    32'(wb_rd_we),   0);
        chk("st.cpsr_we",  32'(wb_cpsr_we), 0);
        chk("st.pc_we",    32'(wb_pc_we),   0);
        chk("st.req_drop", 32'(bus.req),    0);

        // Stray ack while idle is ignored
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("idle_ack.wb_valid", 32'(wb_valid), 0);
        chk("idle_ack.req",      32'(bus.req),  0);

        // Timeout: no ack for TO WAIT cycles
        drive(1, F_LD, 6, 0, 0, 32'h80, 0, 0);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < TO - 1; k++) begin
            tick();
            chk("to.req_held", 32'(bus.req), 1);
        end
        tick();
        chk("to.req_drop", 32'(bus.req),  0);
        chk("to.bus_err",  32'(bus_err),  1);
        chk("to.wb_valid", 32'(wb_valid), 1);
        chk("to.rd_we",    32'(wb_rd_we), 0);
        chk("to.ready",    32'(in_ready), 1);
        tick();
        chk("to.pulse_end", 32'(wb_valid), 0);
        chk("to.err_sticky", 32'(bus_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to.err_clr", 32'(bus_err), 0);

        // Timeout while err_clr is held: set wins
        drive(1, F_LD, 6, 0, 0, 32'h80, 0, 0);
        err_clr = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (TO) tick();
        chk("setwins.bus_err", 32'(bus_err), 1);
        err_clr = 1'b0;
        tick();
        chk("setwins.hold", 32'(bus_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("setwins.clr", 32'(bus_err), 0);

        // Ack on the last WAIT cycle completes normally
        drive(1, F_LD, 4, 0, 0, 32'h44, 0, 0);
        tick();
        in_valid = 1'b0;
        repeat (TO - 1) tick();
        bus.ack   = 1'b1;
        bus.rdata = 32'h0BADF00D;
        tick();
        bus.ack   = 1'b0;
        chk("lastack.wb_valid", 32'(wb_valid),  1);
        chk("lastack.rd_we",    32'(wb_rd_we),  1);
        chk("lastack.rd_num",   32'(wb_rd_num), 4);
        chk("lastack.data",     wb_data,        32'h0BADF00D);
        chk("lastack.bus_err",  32'(bus_err),   0);
        chk("lastack.req",      32'(bus.req),   0);

        // Asynchronous reset in the middle of a WAIT
        drive(1, F_LD, 1, 0, 0, 32'h50, 0, 0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("rstwait.req_before", 32'(bus.req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstwait.req",      32'(bus.req),   0);
        chk("rstwait.addr",     32'(bus.addr),  0);
        chk("rstwait.ready",    32'(in_ready),  1);
        chk("rstwait.wb_data",  wb_data,        0);
        chk("rstwait.wb_rd",    32'(wb_rd_num), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rstwait.wb_valid", 32'(wb_valid), 0);
        chk("rstwait.req_post", 32'(bus.req),  0);
        chk("rstwait.ready_post", 32'(in_ready), 1);

        // Randomized ops against the transaction-level model
        m_rd = '0; m_data = '0; m_cpsr = '0; m_pc = '0; m_err = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [4:0]  fl;
            logic [31:0] res, rdv, md, cp;
            logic [3:0]  rd;
            logic        tk, clr;
            fl  = 5'($urandom_range(0, 31));
            rd  = 4'($urandom_range(0, 15));
            res = $urandom(); rdv = $urandom(); md = $urandom(); cp = 32'($urandom_range(0, 15));
            tk  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 5) == 0);
            m_v = 1'b0; m_rw = 1'b0; m_cw = 1'b0; m_pw = 1'b0;
            if ($urandom_range(0, 4) == 0) begin
                drive(0, fl, rd, res, rdv, md, cp, tk);
                bus.ack = 1'($urandom_range(0, 1));
                err_clr = clr;
                tick();
                bus.ack = 1'b0;
                err_clr = 1'b0;
                if (clr) m_err = 1'b0;
                check_model("rnd_bubble");
            end else if (fl[4] || fl[3]) begin
                int d;
                logic is_ld;
                logic [31:0] rdata;
                is_ld = fl[4];
                d = $urandom_range(0, TO + 1);
                drive(1, fl, rd, res, rdv, md, cp, tk);
                tick();
                in_valid = 1'b0;
                chk("rnd_mem.req",   32'(bus.req),  1);
                chk("rnd_mem.we",    32'(bus.we),   32'(!is_ld));
                chk("rnd_mem.addr",  32'(bus.addr), {10'd0, md[21:0]});
                chk("rnd_mem.wdata", bus.wdata,     rdv);
                chk("rnd_mem.ready", 32'(in_ready), 0);
                rdata = '0;
                for (int k = 0; k < TO; k++) begin
                    bus.ack   = (k == d);
                    bus.rdata = $urandom();
                    if (k == d) rdata = bus.rdata;
                    tick();
                    bus.ack = 1'b0;
                    if (k == d || k == TO - 1) break;
                    chk("rnd_mem.hold_req", 32'(bus.req),  1);
                    chk("rnd_mem.hold_wbv", 32'(wb_valid), 0);
                end
                m_v = 1'b1;
                if (d < TO) begin
                    if (is_ld) begin
                        m_rw = 1'b1; m_rd = rd; m_data = rdata;
                    end
                end else begin
                    m_err = 1'b1;
                end
                check_model(is_ld ? "rnd_ld" : "rnd_st");
            end else begin
                drive(1, fl, rd, res, rdv, md, cp, tk);
                err_clr = clr;
                tick();
                err_clr = 1'b0;
                if (clr) m_err = 1'b0;
                m_v = 1'b1;
                if (fl[2]) begin
                    m_rw = 1'b1; m_rd = rd; m_data = res;
                end else if (fl[1]) begin
                    m_cw = 1'b1; m_cpsr = cp;
                end else if (fl[0]) begin
                    m_pw = tk; m_pc = md;
                end
                check_model("rnd_op");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes execute results and pass-through flags.
- Performs ld/str via a req/ack data-memory handshake, stalling upstream while the access is outstanding.
- Presents registered writeback controls (register file, CPSR, PC) to the writeback stage.

Parameters:
ADDR_W, 22, data-memory address width; address = md[ADDR_W-1:0]
DATA_W, 32, datapath width
TIMEOUT, 255, max cycles waiting for mem_ack before abort (1..2^16-1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  execute outputs valid this cycle
in_ready  output  1  stage can accept (combinational; 1 only in IDLE)
ex_result  input  32  ALU result
ex_rd_num  input  4  destination/source register number
ex_rd_val  input  32  store data (rd value)
ex_md  input  32  sign-extended md: memory address or jump target
ex_cpsr  input  32  {28'd0, nzcv} from comparator
ex_taken  input  1  branch condition met
ex_is_alu, ex_is_cmp, ex_is_jmp, ex_is_ld, ex_is_str  input  1 each  op class flags
mem_req  output  1  memory request (registered)
mem_we  output  1  1=store, 0=load
mem_addr  output  ADDR_W  request address
mem_wdata  output  32  store data
mem_rdata  input  32  load data, valid with mem_ack
mem_ack  input  1  one-cycle completion strobe
wb_valid  output  1  one-cycle pulse: wb_* fields valid
wb_rd_we  output  1  write wb_data to wb_rd_num
wb_rd_num  output  4  destination register
wb_data  output  32  ALU result or load data
wb_cpsr_we  output  1  write wb_cpsr to CPSR
wb_cpsr  output  32  new CPSR value
wb_pc_we  output  1  redirect PC
wb_pc  output  32  jump target
bus_err  output  1  sticky timeout error
err_clr  input  1  clears bus_err

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; all wb_* = 0; bus_err=0. Reset during WAIT drops mem_req immediately and abandons the access; no wb_valid is produced.
- Op priority when several flags are set: ld > str > alu > cmp > jmp. No flag set = nop: wb_valid=1, all write enables 0.
- States: IDLE, WAIT.
- IDLE:
  - in_ready=1.
  - On in_valid with ld/str: next edge sets mem_req=1, mem_we=is_str, mem_addr=ex_md[ADDR_W-1:0], mem_wdata=ex_rd_val; latch ex_rd_num; go WAIT; timeout counter=0.
  - On in_valid with alu/cmp/jmp/nop: next edge registers wb_* with wb_valid=1; stay IDLE. Throughput is 1 op/cycle.
    - alu: wb_rd_we=1, wb_data=ex_result.
    - cmp: wb_cpsr_we=1, wb_cpsr=ex_cpsr.
    - jmp: wb_pc_we=ex_taken, wb_pc=ex_md.
  - mem_ack seen in IDLE is ignored.
- WAIT:
  - in_ready=0. mem_req/mem_we/mem_addr/mem_wdata held stable until completion.
  - Each cycle without mem_ack, the counter increments.
  - On mem_ack: next edge mem_req=0; wb_valid=1; ld: wb_rd_we=1, wb_rd_num=latched rd, wb_data=mem_rdata sampled on the ack cycle; str: all write enables 0; go IDLE. Total ld/str latency: accept edge + 1 + ack wait.
  - Timeout: if counter==TIMEOUT-1 and no mem_ack, next edge mem_req=0, bus_err=1, wb_valid=1 with all write enables 0; go IDLE. A mem_ack in that same cycle wins over the timeout.
- wb_valid and all wb_*_we are single-cycle pulses; they return to 0 the cycle after unless a new op completes. wb_data/wb_rd_num/wb_cpsr/wb_pc hold their last value.
- bus_err: set by timeout, cleared by err_clr. If set and clear occur in the same cycle, set wins.
- Width rules: mem_addr truncates ex_md to ADDR_W; no other arithmetic.

Test Plan:
- alu op, ex_rd_num=3, ex_result=0x1234 -> next cycle wb_valid=1, wb_rd_we=1, wb_rd_num=3, wb_data=0x1234; in_ready stays 1; back-to-back alu ops give consecutive wb_valid pulses.
- ld, ex_md=0x00000040, ex_rd_num=5; mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> mem_req=1, mem_we=0, mem_addr=0x40 held; in_ready=0 throughout; one cycle after ack: wb_rd_we=1, wb_rd_num=5, wb_data=0xDEADBEEF, mem_req=0.
- str, ex_md=0x3FFFFF, ex_rd_val=0xA5A5A5A5, immediate ack -> mem_we=1, mem_addr=0x3FFFFF, mem_wdata=0xA5A5A5A5; wb_valid=1 with all write enables 0.
- cmp with ex_cpsr=0x8, then jmp with ex_taken=1, ex_md=0x100 -> wb_cpsr_we=1, wb_cpsr=0x8; then wb_pc_we=1, wb_pc=0x100. Same jmp with ex_taken=0 -> wb_pc_we=0.
- TIMEOUT=4, ld with no ack -> mem_req drops after 4 WAIT cycles; bus_err=1; wb_valid=1 with no write enables; err_clr clears bus_err; ack arriving on the 4th cycle completes normally with no error.
- rst_n low during WAIT -> mem_req=0 immediately, all outputs 0, state IDLE, in_ready=1 after reset release.
